// File: rtl/social_comfort_fsm.sv
// social_comfort_fsm: stress-driven mood machine for the behaviour-model group.
// A saturating stress accumulator feeds a four-state mood FSM (CALM, ALERT,
// ANXIOUS, RETREAT) with a timed RETREAT cooldown and a one-cycle overload pulse.
//
// Ports:
//   clk            - single clock, rising edge
//   reset          - asynchronous, active-high; clears all state immediately
//   unknown_people - unknown people present this cycle (raises stress)
//   comfort_zone   - in comfort zone this cycle (lowers stress)
//   known_people   - known people present this cycle (lowers stress by 1)
//   out            - mood / state register: 00 CALM, 01 ALERT, 10 ANXIOUS, 11 RETREAT
//   stress         - registered stress level, saturating 0..2^STRESS_W-1
//   retreat_left   - remaining RETREAT cooldown cycles (0 outside RETREAT)
//   overload       - one-cycle pulse on the edge where stress first reaches max
module social_comfort_fsm #(
    parameter int unsigned STRESS_W    = 4,
    parameter int unsigned UNK_STEP    = 3,
    parameter int unsigned CZ_STEP     = 2,
    parameter int unsigned ALERT_TH    = 4,
    parameter int unsigned PANIC_TH    = 10,
    parameter int unsigned RETREAT_CYC = 5
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               unknown_people,
    input  logic                               comfort_zone,
    input  logic                               known_people,
    output logic [1:0]                         out,
    output logic [STRESS_W-1:0]                stress,
    output logic [$clog2(RETREAT_CYC+1)-1:0]   retreat_left,
    output logic                               overload
);

    localparam int unsigned RL_W  = $clog2(RETREAT_CYC + 1);
    localparam int unsigned SUM_W = STRESS_W + 2;

    localparam logic [1:0] CALM    = 2'b00;
    localparam logic [1:0] ALERT   = 2'b01;
    localparam logic [1:0] ANXIOUS = 2'b10;
    localparam logic [1:0] RETREAT = 2'b11;

    localparam logic [STRESS_W-1:0] STRESS_MAX = '1;

    // Reject illegal threshold / cooldown configurations at elaboration.
    if (!(ALERT_TH > 0 && ALERT_TH < PANIC_TH &&
          PANIC_TH <= (2 ** STRESS_W) - 1 && RETREAT_CYC >= 1)) begin : g_bad_cfg
        $error("social_comfort_fsm: illegal parameter configuration");
    end

    logic [1:0]          state_nxt;
    logic [STRESS_W-1:0] stress_nxt;
    logic [RL_W-1:0]     rl_nxt;
    logic                overload_nxt;
    logic [SUM_W-1:0]    inc;
    logic [SUM_W-1:0]    dec;
    logic [SUM_W-1:0]    sum;

    // Stress accumulator, overload detect and mood transitions.
    always_comb begin
        state_nxt    = out;
        rl_nxt       = '0;
        inc          = '0;
        dec          = '0;
        sum          = '0;
        stress_nxt   = stress;
        overload_nxt = 1'b0;

        if (unknown_people && out != RETREAT) begin
            inc = SUM_W'(UNK_STEP);
        end
        if (comfort_zone) begin
            dec = SUM_W'(CZ_STEP);
        end
        if (known_people) begin
            dec = dec + SUM_W'(1);
        end

        // Two spare bits: MSB flags underflow, the next bit flags overflow.
        sum = SUM_W'({2'b00, stress}) + inc - dec;
        if (sum[SUM_W-1]) begin
            stress_nxt = '0;
        end else if (sum[STRESS_W]) begin
            stress_nxt = STRESS_MAX;
        end else begin
            stress_nxt = sum[STRESS_W-1:0];
        end

        overload_nxt = (stress_nxt == STRESS_MAX) && (stress != STRESS_MAX);

        // Transitions use the pre-update stress, so mood lags stress by one edge.
        case (out)
            CALM: begin
                if (stress >= STRESS_W'(ALERT_TH)) begin
                    state_nxt = ALERT;
                end
            end
            ALERT: begin
                if (stress >= STRESS_W'(PANIC_TH)) begin
                    state_nxt = ANXIOUS;
                end else if (stress < STRESS_W'(ALERT_TH) && comfort_zone) begin
                    state_nxt = CALM;
                end
            end
            ANXIOUS: begin
                if (comfort_zone) begin
                    state_nxt = RETREAT;
                    rl_nxt    = RL_W'(RETREAT_CYC);
                end else if (stress < STRESS_W'(PANIC_TH)) begin
                    state_nxt = ALERT;
                end
            end
            default: begin
                // RETREAT: serve the cooldown, then leave only once stress is low.
                if (retreat_left != '0) begin
                    rl_nxt = retreat_left - RL_W'(1);
                end else if (stress < STRESS_W'(ALERT_TH)) begin
                    state_nxt = CALM;
                end
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out          <= CALM;
            stress       <= '0;
            retreat_left <= '0;
            overload     <= 1'b0;
        end else begin
            out          <= state_nxt;
            stress       <= stress_nxt;
            retreat_left <= rl_nxt;
            overload     <= overload_nxt;
        end
    end

endmodule

// File: tb/tb_social_comfort_fsm.sv
// Self-checking bench for social_comfort_fsm: directed scenarios with fixed
// expectations, then randomized stimulus against a behavioural mood model.
module tb_social_comfort_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic       unknown_people;
    logic       comfort_zone;
    logic       known_people;
    logic [1:0] out;
    logic [3:0] stress;
    logic [2:0] retreat_left;
    logic       overload;

    int checks = 0;
    int errors = 0;

    // Reference model state (plain integers; mood 0 CALM .. 3 RETREAT).
    int m_stress = 0;
    int m_mood   = 0;
    int m_rl     = 0;
    int m_ovl    = 0;

    social_comfort_fsm dut (
        .clk            (clk),
        .reset          (reset),
        .unknown_people (unknown_people),
        .comfort_zone   (comfort_zone),
        .known_people   (known_people),
        .out            (out),
        .stress         (stress),
        .retreat_left   (retreat_left),
        .overload       (overload)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_stress = 0;
        m_mood   = 0;
        m_rl     = 0;
        m_ovl    = 0;
    endtask

    // One clock edge of the intended behaviour, computed from the rules directly.
    task automatic model_edge(input bit u, input bit c, input bit k);
        int ns;
        int nm;
        int nrl;
        ns = m_stress + ((u && m_mood != 3) ? 3 : 0) - (c ? 2 : 0) - (k ? 1 : 0);
        if (ns < 0)  ns = 0;
        if (ns > 15) ns = 15;
        m_ovl = (ns == 15 && m_stress < 15) ? 1 : 0;
        nm  = m_mood;
        nrl = 0;
        if (m_mood == 0) begin
            if (m_stress >= 4) nm = 1;
        end else if (m_mood == 1) begin
            if (m_stress >= 10) nm = 2;
            else if (m_stress < 4 && c) nm = 0;
        end else if (m_mood == 2) begin
            if (c) begin
                nm  = 3;
                nrl = 5;
            end else if (m_stress < 10) begin
                nm = 1;
            end
        end else begin
            if (m_rl > 0) nrl = m_rl - 1;
            else if (m_stress < 4) nm = 0;
        end
        m_stress = ns;
        m_mood   = nm;
        m_rl     = nrl;
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".out"},      int'(out),          m_mood);
        check({tag, ".stress"},   int'(stress),       m_stress);
        check({tag, ".rl"},       int'(retreat_left), m_rl);
        check({tag, ".overload"}, int'(overload),     m_ovl);
    endtask

    // Drive inputs, take one edge, sample 1 time unit later and check the model.
    task automatic step(input bit u, input bit c, input bit k, input string tag);
        unknown_people = u;
        comfort_zone   = c;
        known_people   = k;
        @(posedge clk);
        model_edge(u, c, k);
        #1;
        compare_model(tag);
    endtask

    task automatic do_reset();
        unknown_people = 1'b0;
        comfort_zone   = 1'b0;
        known_people   = 1'b0;
        reset          = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        compare_model("reset");
        reset = 1'b0;
    endtask

    // Mid-cycle asynchronous reset; outputs must clear before the next edge.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        compare_model(tag);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int exp_s1[6];
        int exp_o1[6];
        int exp_rl2[5];
        int exp_s2[5];
        int pu;
        int pc;
        int pk;

        exp_s1  = '{3, 6, 9, 12, 15, 15};
        exp_o1  = '{0, 0, 1, 1, 2, 2};
        exp_rl2 = '{4, 3, 2, 1, 0};
        exp_s2  = '{11, 9, 7, 5, 3};

        reset = 1'b1;
        do_reset();

        // Ramp with unknown people: saturation, mood lag, single overload pulse.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 1'b0, "ramp");
            check("ramp.stress_c", int'(stress), exp_s1[i]);
            check("ramp.out_c", int'(out), exp_o1[i]);
            check("ramp.ovl_c", int'(overload), (i == 4) ? 1 : 0);
        end

        // Comfort zone from ANXIOUS: RETREAT entry, cooldown, back to CALM.
        step(1'b0, 1'b1, 1'b0, "entry");
        check("entry.out_c", int'(out), 3);
        check("entry.rl_c", int'(retreat_left), 5);
        check("entry.stress_c", int'(stress), 13);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0, "cool");
            check("cool.rl_c", int'(retreat_left), exp_rl2[i]);
            check("cool.stress_c", int'(stress), exp_s2[i]);
            check("cool.out_c", int'(out), 3);
        end
        step(1'b0, 1'b1, 1'b0, "exit");
        check("exit.out_c", int'(out), 0);
        check("exit.stress_c", int'(stress), 1);

        // RETREAT ignores unknown people; stays while stress is high.
        do_reset();
        repeat (6) step(1'b1, 1'b0, 1'b0, "ramp3");
        step(1'b0, 1'b1, 1'b0, "entry3");
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 1'b0, "hold3");
            check("hold3.stress_c", int'(stress), 13);
            check("hold3.out_c", int'(out), 3);
        end
        check("hold3.rl_c", int'(retreat_left), 0);
        repeat (6) step(1'b0, 1'b1, 1'b0, "drain3");
        check("drain3.out_c", int'(out), 0);

        // ALERT decays with known people only; CALM needs comfort zone.
        do_reset();
        step(1'b1, 1'b0, 1'b0, "up4");
        step(1'b1, 1'b0, 1'b0, "up4");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, "known4");
            check("known4.stress_c", int'(stress), 5 - i);
            check("known4.out_c", int'(out), 1);
        end
        step(1'b0, 1'b1, 1'b0, "calm4");
        check("calm4.out_c", int'(out), 0);

        // All inputs at once nets zero; no underflow wrap at zero.
        do_reset();
        repeat (4) step(1'b1, 1'b1, 1'b1, "all5");
        check("all5.stress_c", int'(stress), 0);
        repeat (3) step(1'b0, 1'b1, 1'b1, "floor5");
        check("floor5.stress_c", int'(stress), 0);
        check("floor5.out_c", int'(out), 0);

        // Asynchronous reset in RETREAT with retreat_left=3.
        repeat (6) step(1'b1, 1'b0, 1'b0, "ramp6");
        step(1'b0, 1'b1, 1'b0, "entry6");
        step(1'b0, 1'b0, 1'b0, "wait6");
        step(1'b0, 1'b0, 1'b0, "wait6");
        check("pre6.rl_c", int'(retreat_left), 3);
        async_reset("async6");
        check("async6.out_c", int'(out), 0);
        check("async6.rl_c", int'(retreat_left), 0);
        step(1'b0, 1'b0, 1'b0, "post6");

        // Randomized phases with varying input bias plus occasional async resets.
        for (int p = 0; p < 30; p++) begin
            pu = int'($urandom_range(0, 100));
            pc = int'($urandom_range(0, 100));
            pk = int'($urandom_range(0, 60));
            for (int i = 0; i < 25; i++) begin
                step(($urandom_range(0, 99) < pu), ($urandom_range(0, 99) < pc),
                     ($urandom_range(0, 99) < pk), "rand");
                if ($urandom_range(0, 199) == 0) begin
                    async_reset("rand_rst");
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/social_comfort_fsm.md
Name: social_comfort_fsm

Overview:
- Parametrised next-generation social-situation FSM.
- Replaces the fixed 2-bit comfort decoder with:
  - a saturating stress accumulator driven by unknown_people, comfort_zone and known_people;
  - a four-state mood machine with thresholds;
  - a timed RETREAT recovery mode;
  - a one-cycle overload pulse.
- Sits in the behaviour-model group and drives 2-bit mood to the same consumers as the earlier block.

Parameters:
- STRESS_W, 4, width of stress accumulator; range 0..2^STRESS_W-1.
- UNK_STEP, 3, stress added per cycle while unknown_people=1.
- CZ_STEP, 2, stress removed per cycle while comfort_zone=1.
- ALERT_TH, 4, stress level at or above which CALM goes to ALERT.
- PANIC_TH, 10, stress level at or above which ALERT goes to ANXIOUS.
- RETREAT_CYC, 5, minimum cooldown cycles spent in RETREAT after entry.
- Legal configuration: 0 < ALERT_TH < PANIC_TH <= 2^STRESS_W-1; RETREAT_CYC >= 1. Violations raise an elaboration-time error.

Ports:
- clk, input, 1, single clock, rising edge.
- reset, input, 1, asynchronous, active-high; clears all state immediately.
- unknown_people, input, 1, unknown people present this cycle.
- comfort_zone, input, 1, in comfort zone this cycle.
- known_people, input, 1, known people present this cycle.
- out, output, 2, mood: 00 CALM, 01 ALERT, 10 ANXIOUS, 11 RETREAT.
- stress, output, STRESS_W, current registered stress level.
- retreat_left, output, $clog2(RETREAT_CYC+1), remaining cooldown count.
- overload, output, 1, one-cycle pulse when stress reaches the maximum.

Behaviour:
- Reset state (asynchronous on reset=1, independent of clk):
  - out=00 (CALM), stress=0, retreat_left=0, overload=0.
  - Deassertion takes effect at the next rising edge.
- All outputs are registered. out is the state register.
- Stress update, every edge:
  - inc = UNK_STEP if unknown_people and state != RETREAT, else 0. RETREAT ignores unknown_people.
  - dec = (comfort_zone ? CZ_STEP : 0) + (known_people ? 1 : 0).
  - next = stress + inc - dec, computed signed at STRESS_W+2 bits.
  - Saturate to 0 below and to 2^STRESS_W-1 above. No wrap-around ever.
  - When all inputs are simultaneously 1, inc and dec both apply in the same cycle.
- overload:
  - Registered. Asserts on the edge where next stress == max and the current stress < max.
  - Held at max means no further pulses.
- State transitions are evaluated on the current registered stress (pre-update value), so the mood lags stress by one edge:
  - CALM: stress >= ALERT_TH -> ALERT.
  - ALERT: stress >= PANIC_TH -> ANXIOUS. Otherwise stress < ALERT_TH and comfort_zone -> CALM. Otherwise stay.
  - ANXIOUS: comfort_zone=1 -> RETREAT, and load retreat_left=RETREAT_CYC. Otherwise stress < PANIC_TH -> ALERT. The comfort_zone check has priority.
  - RETREAT: retreat_left decrements each edge while > 0. When retreat_left==0 and stress < ALERT_TH -> CALM. Otherwise stay; comfort_zone is not required to remain asserted.
- retreat_left is 0 in every state other than RETREAT.
- Reset mid-RETREAT or mid-ramp: everything returns immediately to reset values; no residual cooldown.

Test Plan (default parameters):
1. Reset, then unknown_people=1 held, others 0:
   - stress 3,6,9,12,15,15 on edges 1-6.
   - out CALM, CALM, ALERT, ALERT, ANXIOUS, ANXIOUS.
   - overload=1 only in the cycle after edge 5.
2. From scenario 1 end, unknown=0, comfort_zone=1:
   - Entry edge: out=11, retreat_left=5, stress=13.
   - Then retreat_left 4,3,2,1,0 with stress 11,9,7,5,3.
   - Next edge: out=00, stress=1.
3. In RETREAT, assert unknown_people=1 with comfort_zone=0:
   - stress does not increase.
   - retreat_left still counts down.
   - Stays RETREAT while stress >= 4 after count reaches 0.
4. In ALERT at stress=6, known_people=1 only:
   - stress 5,4,3.
   - out stays ALERT (no comfort_zone) until comfort_zone=1 with stress < 4 -> CALM.
5. All three inputs=1 from stress=0:
   - net +0 per cycle (3-2-1), so stress stays 0 and out stays CALM.
   - Separately, comfort_zone+known_people at stress=0 stays at 0 (no underflow wrap).
6. Assert reset asynchronously mid-cycle while in RETREAT with retreat_left=3:
   - out=00, stress=0, retreat_left=0, overload=0 immediately, before the next clk edge.
